keypad_scan_4x4: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment display driver. It drives the rows of a 4x4 matrix keypad one at a time and reads back the column lines.
- Each press is debounced and becomes a 4-bit key code.
- Codes are buffered in a small FIFO and delivered over a valid/ready handshake to the calculator top. This replaces the per-button debounce chain for operand entry.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/key_fifo.sv | 56 +++++
 rtl/keypad_scan_4x4.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scan_4x4.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: geometry, code type,
// scanner state encoding and the row-index to row-drive decode.
package keypad_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_CODE_W = 4;

  typedef logic [KP_CODE_W-1:0] kp_code_t;

  localparam logic [1:0] ST_SETTLE     = 2'd0;
  localparam logic [1:0] ST_SAMPLE     = 2'd1;
  localparam logic [1:0] ST_PRESS_DB   = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  // Active-low drive pattern: only the selected row is pulled low.
  function automatic logic [KP_ROWS-1:0] row_drive(input logic [1:0] idx);
    logic [KP_ROWS-1:0] one_hot;
    one_hot      = '0;
    one_hot[idx] = 1'b1;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for key codes; a push into a full FIFO is accepted
// only when a pop happens in the same cycle. Head reads as zero when empty.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("key_fifo DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: row drive, column sync, press/release debounce
// and a key-code FIFO. Optional auto-repeat under KEYPAD_AUTOREPEAT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// SETTLE      | row driven, waiting for columns to settle through the sync
// SAMPLE      | inspect columns once: idle, single key, or ghost/multi-key
// PRESS_DB    | row held, candidate pattern must stay stable to accept
// RELEASE_DB  | row held, all columns must stay high to finish the press
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [KP_ROWS-1:0]   row_n,
  input  logic [KP_COLS-1:0]   col_n,
  output logic                 key_valid,
  output logic [KP_CODE_W-1:0] key_code,
  input  logic                 key_ready,
  output logic                 key_held,
  output logic                 overflow
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KP_COLS-1:0] col_meta;
  logic [KP_COLS-1:0] col_s;
  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         row_idx;
  logic [1:0]         row_next;
  kp_code_t           cand;
  logic [KP_COLS-1:0] pattern;
  logic               col_idle;
  logic               col_single;
  logic [1:0]         col_idx;
  logic               press_done;
  logic               rep_fire;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_s    <= '1;
    end else begin
      col_meta <= col_n;
      col_s    <= col_meta;
    end
  end

  assign col_idle = (col_s == '1);
  assign row_next = row_idx + 2'd1;

  always_comb begin
    col_single = 1'b0;
    col_idx    = 2'd0;
    case (col_s)
      4'b1110: begin col_single = 1'b1; col_idx = 2'd0; end
      4'b1101: begin col_single = 1'b1; col_idx = 2'd1; end
      4'b1011: begin col_single = 1'b1; col_idx = 2'd2; end
      4'b0111: begin col_single = 1'b1; col_idx = 2'd3; end
      default: begin col_single = 1'b0; col_idx = 2'd0; end
    endcase
  end

  assign press_done = (state == ST_PRESS_DB) && (col_s == pattern) && (cnt == DB_LAST);
  assign push       = press_done || rep_fire;
  assign key_valid  = !fifo_empty;
  assign pop        = key_valid && key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SETTLE;
      cnt      <= '0;
      row_idx  <= 2'd0;
      row_n    <= row_drive(2'd0);
      cand     <= '0;
      pattern  <= '1;
      key_held <= 1'b0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (col_single) begin
            cand    <= {row_idx, col_idx};
            pattern <= col_s;
            state   <= ST_PRESS_DB;
          end else begin
            row_idx <= row_next;
            row_n   <= row_drive(row_next);
            state   <= ST_SETTLE;
          end
          cnt <= '0;
        end
        ST_PRESS_DB: begin
          if (col_s != pattern) begin
            cnt     <= '0;
            row_idx <= row_next;
            row_n   <= row_drive(row_next);
            state   <= ST_SETTLE;
          end else if (cnt == DB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b1;
            state    <= ST_RELEASE_DB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE_DB: begin
          // Any low column restarts the release count; other keys are ignored.
          if (!col_idle) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            row_idx  <= row_next;
            row_n    <= row_drive(row_next);
            state    <= ST_SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_SETTLE;
        end
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic             key_down;

  // The latched key's own column is still low.
  assign key_down = ((col_s | pattern) != '1);
  assign rep_fire = (state == ST_RELEASE_DB) && key_down &&
                    (rep_cnt == (rep_first ? DELAY_LAST : PERIOD_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if ((state != ST_RELEASE_DB) || !key_down) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  key_fifo #(
    .WIDTH(KP_CODE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(cand),
    .pop      (pop),
    .pop_data (key_code),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with a behavioural keypad matrix model.
module tb_keypad_scan_4x4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        key_held;
  logic        overflow;
  logic [15:0] pressed;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  keypad_scan_4x4 #(
    .SETTLE_CYCLES  (2),
    .DEBOUNCE_CYCLES(8),
    .FIFO_DEPTH     (4),
    .REPEAT_DELAY   (100),
    .REPEAT_PERIOD  (50)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_held (key_held),
    .overflow (overflow)
  );

  task automatic test_reset();
    logic [3:0] exp_rows [4];
    exp_rows[0] = 4'b1110;
    exp_rows[1] = 4'b1101;
    exp_rows[2] = 4'b1011;
    exp_rows[3] = 4'b0111;
    pressed   = '0;
    key_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (row_n !== 4'b1110) begin miscompares++; $display("FAIL reset_row_n: got %b want 1110", row_n); end
    vectors++;
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    vectors++;
    if (key_code !== 4'd0) begin miscompares++; $display("FAIL reset_key_code: got %0d want 0", key_code); end
    vectors++;
    if (key_held !== 1'b0) begin miscompares++; $display("FAIL reset_key_held: got %b want 0", key_held); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      vectors++;
      if (row_n !== exp_rows[(k/3)%4]) begin
        miscompares++;
        $display("FAIL scan_row_n[%0d]: got %b want %b", k, row_n, exp_rows[(k/3)%4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_press();
    int lat;
    lat = -1;
    pressed    = '0;
    pressed[9] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (key_valid && lat < 0) lat = k;
    end
    vectors++;
    if (lat < 0 || lat > 24) begin miscompares++; $display("FAIL press_latency: got %0d cycles want 1..24", lat); end
    vectors++;
    if (key_valid !== 1'b1) begin miscompares++; $display("FAIL press_key_valid: got %b want 1", key_valid); end
    vectors++;
    if (key_code !== 4'd9) begin miscompares++; $display("FAIL press_key_code: got %0d want 9", key_code); end
    vectors++;
    if (key_held !== 1'b1) begin miscompares++; $display("FAIL press_key_held: got %b want 1", key_held); end
    pressed = '0;
    repeat (9) @(negedge clk);
    vectors++;
    if (key_held !== 1'b1) begin miscompares++; $display("FAIL release_early: got key_held %b want 1", key_held); end
    @(negedge clk);
    vectors++;
    if (key_held !== 1'b0) begin miscompares++; $display("FAIL release_done: got key_held %b want 0", key_held); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    vectors++;
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL single_entry: got key_valid %b want 0 after one pop", key_valid); end
  endtask

  task automatic test_glitch();
    logic seen_valid;
    logic seen_held;
    logic [3:0] rows_seen;
    seen_valid = 1'b0;
    seen_held  = 1'b0;
    rows_seen  = '0;
    pressed    = '0;
    pressed[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      seen_valid |= key_valid;
      seen_held  |= key_held;
    end
    pressed = '0;
    repeat (30) begin
      @(negedge clk);
      seen_valid |= key_valid;
      seen_held  |= key_held;
    end
    repeat (12) begin
      @(negedge clk);
      rows_seen |= ~row_n;
    end
    vectors++;
    if (seen_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_no_entry: got key_valid seen %b want 0", seen_valid); end
    vectors++;
    if (seen_held !== 1'b0) begin miscompares++; $display("FAIL glitch_no_held: got key_held seen %b want 0", seen_held); end
    vectors++;
    if (rows_seen !== 4'hF) begin miscompares++; $display("FAIL glitch_scan_resumes: got rows %b want 1111", rows_seen); end
  endtask

  task automatic test_ghost();
    logic seen_valid;
    logic seen_held;
    seen_valid = 1'b0;
    seen_held  = 1'b0;
    pressed    = '0;
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    repeat (40) begin
      @(negedge clk);
      seen_valid |= key_valid;
      seen_held  |= key_held;
    end
    pressed = '0;
    repeat (20) @(negedge clk);
    vectors++;
    if (seen_valid !== 1'b0) begin miscompares++; $display("FAIL ghost_no_entry: got key_valid seen %b want 0", seen_valid); end
    vectors++;
    if (seen_held !== 1'b0) begin miscompares++; $display("FAIL ghost_no_held: got key_held seen %b want 0", seen_held); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL ghost_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    int codes [5];
    int n;
    codes[0] = 1; codes[1] = 2; codes[2] = 3; codes[3] = 4; codes[4] = 5;
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pressed           = '0;
      pressed[codes[i]] = 1'b1;
      n = 0;
      while (!key_held && n < 40) begin @(negedge clk); n++; end
      vectors++;
      if (key_held !== 1'b1) begin miscompares++; $display("FAIL ovf_press_%0d: got key_held %b want 1 within 40 cycles", codes[i], key_held); end
      pressed = '0;
      n = 0;
      while (key_held && n < 20) begin @(negedge clk); n++; end
      vectors++;
      if (key_held !== 1'b0) begin miscompares++; $display("FAIL ovf_release_%0d: got key_held %b want 0 within 20 cycles", codes[i], key_held); end
      repeat (2) @(negedge clk);
      if (i == 3) begin
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_at_full: got overflow %b want 0", overflow); end
      end
    end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got overflow %b want 1", overflow); end
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (key_valid !== 1'b1 || key_code !== 4'(codes[i])) begin
        miscompares++;
        $display("FAIL drain_%0d: got valid %b code %0d want valid 1 code %0d", i, key_valid, key_code, codes[i]);
      end
      @(negedge clk);
    end
    key_ready = 1'b0;
    vectors++;
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty: got key_valid %b want 0", key_valid); end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_still_set: got overflow %b want 1", overflow); end
  endtask

  task automatic test_reset_mid_press();
    int n;
    pressed = '0;
    n = 0;
    while (row_n !== 4'b1110 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (row_n !== 4'b1110) begin miscompares++; $display("FAIL mid_wait_row0: got %b want 1110 within 20 cycles", row_n); end
    pressed[7] = 1'b1;
    n = 0;
    while (row_n !== 4'b1101 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (row_n !== 4'b1101) begin miscompares++; $display("FAIL mid_wait_row1: got %b want 1101 within 20 cycles", row_n); end
    repeat (5) @(negedge clk);
    vectors++;
    if (key_held !== 1'b0 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_pre_reset: got held %b valid %b want 0 0", key_held, key_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (row_n !== 4'b1110) begin miscompares++; $display("FAIL mid_reset_row_n: got %b want 1110", row_n); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL mid_reset_overflow: got %b want 0", overflow); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL mid_after_reset_valid: got %b want 0", key_valid); end
    n = 0;
    while (!key_valid && n < 30) begin @(negedge clk); n++; end
    vectors++;
    if (key_valid !== 1'b1 || key_code !== 4'd7) begin
      miscompares++;
      $display("FAIL mid_redetect: got valid %b code %0d want valid 1 code 7", key_valid, key_code);
    end
    pressed = '0;
    n = 0;
    while (key_held && n < 20) begin @(negedge clk); n++; end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    vectors++;
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL mid_single_entry: got key_valid %b want 0", key_valid); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_ghost();
    test_overflow();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
